// File: rtl/mem_stage_pkg.sv
// Shared constants, FSM encoding and alignment helper for the memory-access stage.
package mem_stage_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic {
    MS_IDLE   = 1'b0,
    MS_ACCESS = 1'b1
  } ms_state_e;

  // Size code 3 is treated as a word access.
  function automatic logic is_misaligned(input logic [1:0] lane, input logic [1:0] size);
    case (size)
      MEM_SIZE_BYTE: is_misaligned = 1'b0;
      MEM_SIZE_HALF: is_misaligned = lane[0];
      default:       is_misaligned = (lane != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane formatting: store data/byte-enables and extended load data.
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [1:0]        lane_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  input  logic [DWIDTH-1:0] rt_i,
  input  logic [DWIDTH-1:0] rdata_i,
  output logic [DWIDTH-1:0] wdata_o,
  output logic [3:0]        be_o,
  output logic [DWIDTH-1:0] ldata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    wdata_o  = rt_i;
    be_o     = 4'b1111;
    ldata_o  = rdata_i;
    case (size_i)
      MEM_SIZE_BYTE: begin
        wdata_o = {NUM_LANES{rt_i[7:0]}};
        be_o    = 4'b0001 << lane_i;
        ldata_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
      end
      MEM_SIZE_HALF: begin
        wdata_o = {2{rt_i[15:0]}};
        be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
        ldata_o = {{16{~uns_i & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/ack data-memory transaction with one registered
// writeback record per accepted operation.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_i_valid,
  output logic              m_o_ready,
  input  logic [DWIDTH-1:0] m_i_alu_value,
  input  logic [DWIDTH-1:0] m_i_data_rt,
  input  logic              m_i_mem_read,
  input  logic              m_i_mem_write,
  input  logic [1:0]        m_i_size,
  input  logic              m_i_unsigned,
  input  logic              m_i_reg_write,
  input  logic [4:0]        m_i_rd,
  output logic              d_o_req,
  output logic              d_o_we,
  output logic [AWIDTH-1:0] d_o_addr,
  output logic [DWIDTH-1:0] d_o_wdata,
  output logic [3:0]        d_o_be,
  input  logic              d_i_ack,
  input  logic [DWIDTH-1:0] d_i_rdata,
  output logic              m_o_wb_valid,
  output logic [DWIDTH-1:0] m_o_wb_data,
  output logic [4:0]        m_o_wb_rd,
  output logic              m_o_wb_reg_write,
  output logic              m_o_misalign
);

  ms_state_e         state_q;
  logic [1:0]        lane_q, size_q;
  logic              uns_q, rw_q;
  logic [4:0]        rd_q;
  logic [DWIDTH-1:0] addr_full_q;

  logic [1:0]        lane, size;
  logic              uns;
  logic [DWIDTH-1:0] fmt_wdata, fmt_ldata;
  logic [3:0]        fmt_be;
  logic              mem_op, misal;

  // The aligner formats store data from live inputs while idle, and
  // load data from the latched lane/size while the access is in flight.
  assign lane   = (state_q == MS_IDLE) ? m_i_alu_value[1:0] : lane_q;
  assign size   = (state_q == MS_IDLE) ? m_i_size : size_q;
  assign uns    = (state_q == MS_IDLE) ? m_i_unsigned : uns_q;
  assign mem_op = m_i_mem_read | m_i_mem_write;
  assign misal  = is_misaligned(m_i_alu_value[1:0], m_i_size);

  assign m_o_ready = (state_q == MS_IDLE);

  mem_align #(.DWIDTH(DWIDTH)) u_align (
    .lane_i  (lane),
    .size_i  (size),
    .uns_i   (uns),
    .rt_i    (m_i_data_rt),
    .rdata_i (d_i_rdata),
    .wdata_o (fmt_wdata),
    .be_o    (fmt_be),
    .ldata_o (fmt_ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= MS_IDLE;
      lane_q           <= '0;
      size_q           <= '0;
      uns_q            <= 1'b0;
      rw_q             <= 1'b0;
      rd_q             <= '0;
      addr_full_q      <= '0;
      d_o_req          <= 1'b0;
      d_o_we           <= 1'b0;
      d_o_addr         <= '0;
      d_o_wdata        <= '0;
      d_o_be           <= '0;
      m_o_wb_valid     <= 1'b0;
      m_o_wb_data      <= '0;
      m_o_wb_rd        <= '0;
      m_o_wb_reg_write <= 1'b0;
      m_o_misalign     <= 1'b0;
    end else begin
      m_o_wb_valid <= 1'b0;
      m_o_misalign <= 1'b0;
      case (state_q)
        MS_IDLE: if (m_i_valid) begin
          if (!mem_op) begin
            m_o_wb_valid     <= 1'b1;
            m_o_wb_data      <= m_i_alu_value;
            m_o_wb_rd        <= m_i_rd;
            m_o_wb_reg_write <= m_i_reg_write;
          end else if (misal) begin
            m_o_wb_valid     <= 1'b1;
            m_o_misalign     <= 1'b1;
            m_o_wb_data      <= m_i_alu_value;
            m_o_wb_rd        <= m_i_rd;
            m_o_wb_reg_write <= 1'b0;
          end else begin
            state_q     <= MS_ACCESS;
            lane_q      <= m_i_alu_value[1:0];
            size_q      <= m_i_size;
            uns_q       <= m_i_unsigned;
            rw_q        <= m_i_reg_write & ~m_i_mem_write;
            rd_q        <= m_i_rd;
            addr_full_q <= m_i_alu_value;
            d_o_req     <= 1'b1;
            d_o_we      <= m_i_mem_write;
            d_o_addr    <= {m_i_alu_value[AWIDTH-1:2], 2'b00};
            d_o_wdata   <= fmt_wdata;
            d_o_be      <= fmt_be;
          end
        end
        MS_ACCESS: if (d_i_ack) begin
          state_q          <= MS_IDLE;
          d_o_req          <= 1'b0;
          d_o_we           <= 1'b0;
          m_o_wb_valid     <= 1'b1;
          m_o_wb_data      <= d_o_we ? addr_full_q : fmt_ldata;
          m_o_wb_rd        <= rd_q;
          m_o_wb_reg_write <= rw_q;
        end
        default: state_q <= MS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_i_valid, m_o_ready;
  logic [31:0] m_i_alu_value, m_i_data_rt;
  logic        m_i_mem_read, m_i_mem_write;
  logic [1:0]  m_i_size;
  logic        m_i_unsigned, m_i_reg_write;
  logic [4:0]  m_i_rd;
  logic        d_o_req, d_o_we;
  logic [31:0] d_o_addr, d_o_wdata;
  logic [3:0]  d_o_be;
  logic        d_i_ack;
  logic [31:0] d_i_rdata;
  logic        m_o_wb_valid;
  logic [31:0] m_o_wb_data;
  logic [4:0]  m_o_wb_rd;
  logic        m_o_wb_reg_write, m_o_misalign;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_i_valid(m_i_valid), .m_o_ready(m_o_ready),
    .m_i_alu_value(m_i_alu_value), .m_i_data_rt(m_i_data_rt),
    .m_i_mem_read(m_i_mem_read), .m_i_mem_write(m_i_mem_write),
    .m_i_size(m_i_size), .m_i_unsigned(m_i_unsigned),
    .m_i_reg_write(m_i_reg_write), .m_i_rd(m_i_rd),
    .d_o_req(d_o_req), .d_o_we(d_o_we), .d_o_addr(d_o_addr),
    .d_o_wdata(d_o_wdata), .d_o_be(d_o_be),
    .d_i_ack(d_i_ack), .d_i_rdata(d_i_rdata),
    .m_o_wb_valid(m_o_wb_valid), .m_o_wb_data(m_o_wb_data),
    .m_o_wb_rd(m_o_wb_rd), .m_o_wb_reg_write(m_o_wb_reg_write),
    .m_o_misalign(m_o_misalign)
  );

  task automatic idle_inputs();
    m_i_valid = 0; m_i_alu_value = 0; m_i_data_rt = 0;
    m_i_mem_read = 0; m_i_mem_write = 0; m_i_size = 2'd2;
    m_i_unsigned = 0; m_i_reg_write = 0; m_i_rd = 0;
  endtask

  // Drives inputs on negedge; outputs are sampled on negedges, mid-cycle.
  task automatic test_reset();
    idle_inputs();
    d_i_ack = 0; d_i_rdata = 0;
    rst_n = 0;
    #2;
    n_checks++;
    if ({d_o_req, d_o_we, d_o_be, m_o_wb_valid, m_o_misalign, m_o_wb_reg_write} !== 9'd0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 0",
        {d_o_req, d_o_we, d_o_be, m_o_wb_valid, m_o_misalign, m_o_wb_reg_write});
    end
    n_checks++;
    if ({d_o_addr, d_o_wdata, m_o_wb_data, m_o_wb_rd} !== 101'd0) begin
      n_fail++; $display("FAIL reset_data got %h/%h/%h/%h want 0",
        d_o_addr, d_o_wdata, m_o_wb_data, m_o_wb_rd);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_checks++;
    if (m_o_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %b want 1", m_o_ready);
    end
  endtask

  task automatic test_passthrough();
    logic [31:0] vals [3] = '{32'd5, 32'd6, 32'd7};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      m_i_valid = 1; m_i_alu_value = vals[i]; m_i_rd = 5'(i + 1); m_i_reg_write = 1;
      @(negedge clk);
      n_checks++;
      if (m_o_wb_valid !== 1'b1 || m_o_wb_data !== vals[i] || m_o_wb_rd !== 5'(i + 1)
          || m_o_wb_reg_write !== 1'b1) begin
        n_fail++; $display("FAIL pass_wb[%0d] got v=%b d=%h rd=%0d rw=%b want v=1 d=%h rd=%0d rw=1",
          i, m_o_wb_valid, m_o_wb_data, m_o_wb_rd, m_o_wb_reg_write, vals[i], i + 1);
      end
      n_checks++;
      if (m_o_ready !== 1'b1 || d_o_req !== 1'b0) begin
        n_fail++; $display("FAIL pass_hs[%0d] got ready=%b req=%b want 1/0", i, m_o_ready, d_o_req);
      end
    end
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (m_o_wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL pass_end got wb_valid=%b want 0", m_o_wb_valid);
    end
  endtask

  task automatic run_mem(input string name, input logic [31:0] addr, input logic [31:0] rt,
                         input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] rdata, input int waits,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
    m_i_valid = 1; m_i_alu_value = addr; m_i_data_rt = rt;
    m_i_mem_read = ~wr; m_i_mem_write = wr; m_i_size = size;
    m_i_unsigned = uns; m_i_reg_write = 1; m_i_rd = 5'd9;
    @(negedge clk);
    n_checks++;
    if (m_o_ready !== 1'b0 || d_o_req !== 1'b1 || d_o_we !== wr || d_o_addr !== exp_addr
        || d_o_be !== exp_be) begin
      n_fail++; $display("FAIL %s_req got rdy=%b req=%b we=%b a=%h be=%b want 0/1/%b/%h/%b",
        name, m_o_ready, d_o_req, d_o_we, d_o_addr, d_o_be, wr, exp_addr, exp_be);
    end
    if (wr) begin
      n_checks++;
      if (d_o_wdata !== exp_wdata) begin
        n_fail++; $display("FAIL %s_wdata got %h want %h", name, d_o_wdata, exp_wdata);
      end
    end
    idle_inputs();
    repeat (waits) @(negedge clk);
    n_checks++;
    if (d_o_req !== 1'b1 || d_o_addr !== exp_addr || m_o_wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_hold got req=%b a=%h wbv=%b want 1/%h/0",
        name, d_o_req, d_o_addr, m_o_wb_valid, exp_addr);
    end
    d_i_ack = 1; d_i_rdata = rdata;
    @(negedge clk);
    d_i_ack = 0; d_i_rdata = 0;
    n_checks++;
    if (m_o_wb_valid !== 1'b1 || m_o_wb_reg_write !== ~wr || m_o_misalign !== 1'b0
        || m_o_wb_rd !== 5'd9 || m_o_ready !== 1'b1 || d_o_req !== 1'b0) begin
      n_fail++; $display("FAIL %s_wb got v=%b rw=%b mis=%b rd=%0d rdy=%b req=%b want 1/%b/0/9/1/0",
        name, m_o_wb_valid, m_o_wb_reg_write, m_o_misalign, m_o_wb_rd, m_o_ready, d_o_req, ~wr);
    end
    if (!wr) begin
      n_checks++;
      if (m_o_wb_data !== exp_wb) begin
        n_fail++; $display("FAIL %s_data got %h want %h", name, m_o_wb_data, exp_wb);
      end
    end
    @(negedge clk);
    n_checks++;
    if (m_o_wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_pulse got wb_valid=%b want 0", name, m_o_wb_valid);
    end
  endtask

  task automatic test_store();
    run_mem("st_byte", 32'h1003, 32'h0000_00AB, 1, 2'd0, 0, 0, 3,
            32'h1000, 4'b1000, 32'hABAB_ABAB, 0);
    run_mem("st_half", 32'h1002, 32'h1234_ABCD, 1, 2'd1, 0, 0, 0,
            32'h1000, 4'b1100, 32'hABCD_ABCD, 0);
    run_mem("st_word", 32'h1004, 32'hCAFE_F00D, 1, 2'd3, 0, 0, 1,
            32'h1004, 4'b1111, 32'hCAFE_F00D, 0);
  endtask

  task automatic test_load();
    run_mem("ld_byte_s", 32'h2001, 0, 0, 2'd0, 0, 32'h1234_80FF, 0,
            32'h2000, 4'b0010, 0, 32'hFFFF_FF80);
    run_mem("ld_byte_u", 32'h2001, 0, 0, 2'd0, 1, 32'h1234_80FF, 2,
            32'h2000, 4'b0010, 0, 32'h0000_0080);
    run_mem("ld_half_s", 32'h2002, 0, 0, 2'd1, 0, 32'h8001_0000, 1,
            32'h2000, 4'b1100, 0, 32'hFFFF_8001);
    run_mem("ld_word", 32'h2004, 0, 0, 2'd2, 0, 32'h8765_4321, 0,
            32'h2004, 4'b1111, 0, 32'h8765_4321);
  endtask

  task automatic test_misalign();
    m_i_valid = 1; m_i_alu_value = 32'h3002; m_i_mem_read = 1; m_i_size = 2'd2;
    m_i_reg_write = 1; m_i_rd = 5'd4;
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (d_o_req !== 1'b0 || m_o_wb_valid !== 1'b1 || m_o_misalign !== 1'b1
        || m_o_wb_reg_write !== 1'b0 || m_o_ready !== 1'b1) begin
      n_fail++; $display("FAIL misalign got req=%b v=%b mis=%b rw=%b rdy=%b want 0/1/1/0/1",
        d_o_req, m_o_wb_valid, m_o_misalign, m_o_wb_reg_write, m_o_ready);
    end
    @(negedge clk);
    n_checks++;
    if (m_o_misalign !== 1'b0 || m_o_wb_valid !== 1'b0 || d_o_req !== 1'b0) begin
      n_fail++; $display("FAIL misalign_pulse got mis=%b v=%b req=%b want 0/0/0",
        m_o_misalign, m_o_wb_valid, d_o_req);
    end
  endtask

  task automatic test_idle_ack();
    d_i_ack = 1; d_i_rdata = 32'h5555_5555;
    repeat (2) @(negedge clk);
    n_checks++;
    if (d_o_req !== 1'b0 || m_o_wb_valid !== 1'b0 || m_o_ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_ack got req=%b v=%b rdy=%b want 0/0/1",
        d_o_req, m_o_wb_valid, m_o_ready);
    end
    d_i_ack = 0; d_i_rdata = 0;
  endtask

  task automatic test_reset_mid_access();
    int wb_seen = 0;
    m_i_valid = 1; m_i_alu_value = 32'h2004; m_i_mem_read = 1; m_i_size = 2'd2;
    m_i_reg_write = 1; m_i_rd = 5'd7;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 0;
    #1;
    n_checks++;
    if (d_o_req !== 1'b0 || m_o_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_abort got req=%b rdy=%b want 0/1", d_o_req, m_o_ready);
    end
    @(negedge clk);
    rst_n = 1;
    d_i_ack = 1; d_i_rdata = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (m_o_wb_valid === 1'b1) wb_seen++;
    end
    d_i_ack = 0; d_i_rdata = 0;
    n_checks++;
    if (wb_seen != 0 || m_o_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_no_retire got wb_count=%0d rdy=%b want 0/1", wb_seen, m_o_ready);
    end
    run_mem("post_rst", 32'h2004, 0, 0, 2'd2, 0, 32'hDEAD_BEEF, 1,
            32'h2004, 4'b1111, 0, 32'hDEAD_BEEF);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_store();
    test_load();
    test_misalign();
    test_idle_ack();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
